// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
package fetch_stage_pkg;

    // Fetch FSM encodings, kept as plain 2-bit constants for older code
    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_RUN  = 2'd1;
    localparam logic [1:0] FETCH_HOLD = 2'd2;

    // Bytes per instruction word; PC advances by this amount
    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches over req/ack,
// delivers each instruction with a one-cycle valid pulse, buffers one word
// under downstream stall and discards stale fetches after a redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned             PC_WIDTH = 32,
    parameter int unsigned             IWIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC = '0
) (
    input  logic                d_clk,
    input  logic                d_rst,
    input  logic                f_i_stall,
    input  logic                f_i_redirect,
    input  logic [PC_WIDTH-1:0] f_i_redirect_pc,
    output logic                f_o_imem_req,
    output logic [PC_WIDTH-1:0] f_o_imem_addr,
    input  logic                f_i_imem_ack,
    input  logic [IWIDTH-1:0]   f_i_imem_data,
    output logic [IWIDTH-1:0]   f_o_instr,
    output logic [PC_WIDTH-1:0] f_o_pc,
    output logic                f_o_ce
);

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                drop_q, drop_d;
    logic                req_q, req_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [IWIDTH-1:0]   instr_q, instr_d;
    logic [PC_WIDTH-1:0] opc_q, opc_d;
    logic                ce_q, ce_d;
    logic [IWIDTH-1:0]   hbuf_instr_q, hbuf_instr_d;
    logic [PC_WIDTH-1:0] hbuf_pc_q, hbuf_pc_d;

    logic [PC_WIDTH-1:0] redirect_tgt;
    logic [PC_WIDTH-1:0] addr_next;

    // Targets are word aligned; sequential address wraps naturally
    assign redirect_tgt = f_i_redirect_pc & ~PC_WIDTH'(INSTR_BYTES - 1);
    assign addr_next    = addr_q + PC_WIDTH'(INSTR_BYTES);

    // Next-state: redirect dominates, then ack handling, then hold release
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        req_d        = req_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        opc_d        = opc_q;
        ce_d         = 1'b0;
        hbuf_instr_d = hbuf_instr_q;
        hbuf_pc_d    = hbuf_pc_q;

        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_RUN;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end
            FETCH_RUN: begin
                if (f_i_redirect) begin
                    pc_d = redirect_tgt;
                    if (f_i_imem_ack) begin
                        // Returning word is stale; reissue at target now
                        addr_d = redirect_tgt;
                        drop_d = 1'b0;
                    end else begin
                        // Request cannot be retracted; discard it on arrival
                        drop_d = 1'b1;
                    end
                end else if (f_i_imem_ack) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                        addr_d = pc_q;
                    end else begin
                        pc_d = addr_next;
                        if (!f_i_stall) begin
                            ce_d    = 1'b1;
                            instr_d = f_i_imem_data;
                            opc_d   = addr_q;
                            addr_d  = addr_next;
                        end else begin
                            hbuf_instr_d = f_i_imem_data;
                            hbuf_pc_d    = addr_q;
                            req_d        = 1'b0;
                            state_d      = FETCH_HOLD;
                        end
                    end
                end
            end
            FETCH_HOLD: begin
                if (f_i_redirect) begin
                    // Buffered word is abandoned by leaving HOLD
                    pc_d    = redirect_tgt;
                    addr_d  = redirect_tgt;
                    req_d   = 1'b1;
                    state_d = FETCH_RUN;
                end else if (!f_i_stall) begin
                    ce_d    = 1'b1;
                    instr_d = hbuf_instr_q;
                    opc_d   = hbuf_pc_q;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = FETCH_RUN;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                req_d   = 1'b0;
                drop_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            state_q      <= FETCH_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            instr_q      <= '0;
            opc_q        <= '0;
            ce_q         <= 1'b0;
            hbuf_instr_q <= '0;
            hbuf_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            opc_q        <= opc_d;
            ce_q         <= ce_d;
            hbuf_instr_q <= hbuf_instr_d;
            hbuf_pc_q    <= hbuf_pc_d;
        end
    end

    assign f_o_imem_req  = req_q;
    assign f_o_imem_addr = addr_q;
    assign f_o_instr     = instr_q;
    assign f_o_pc        = opc_q;
    assign f_o_ce        = ce_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// latency/redirect/reset sequences, and a randomized run against a
// program-order reference model.
module tb_fetch_stage;

    logic        d_clk = 1'b0;
    logic        d_rst = 1'b0;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] instr, pc;
    logic        ce;

    logic        req2, ce2;
    logic [31:0] addr2, data2, instr2, pc2;

    int total = 0;
    int bad   = 0;

    int lat = 1;
    int cnt = 0;
    logic rnd_mode = 1'b0;
    logic rnd_ack  = 1'b0;

    logic        p_req, p_ack, p_stall, p_redir;
    logic [31:0] p_addr, p_tgt;

    always #5 d_clk = ~d_clk;

    // Memory image: two fixed words at 0/4, address-derived words elsewhere
    function automatic logic [31:0] mw(input logic [31:0] a);
        if (a == 32'h0) return 32'h0022_1820;
        if (a == 32'h4) return 32'h8C43_0004;
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Memory acks after lat cycles of a held request, or randomly
    assign imem_ack  = imem_req && (rnd_mode ? rnd_ack : (cnt >= lat - 1));
    assign imem_data = mw(imem_addr);
    assign data2     = mw(addr2);

    fetch_stage dut (
        .d_clk(d_clk), .d_rst(d_rst),
        .f_i_stall(stall), .f_i_redirect(redirect), .f_i_redirect_pc(redirect_pc),
        .f_o_imem_req(imem_req), .f_o_imem_addr(imem_addr),
        .f_i_imem_ack(imem_ack), .f_i_imem_data(imem_data),
        .f_o_instr(instr), .f_o_pc(pc), .f_o_ce(ce)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .d_clk(d_clk), .d_rst(d_rst),
        .f_i_stall(1'b0), .f_i_redirect(1'b0), .f_i_redirect_pc(32'h0),
        .f_o_imem_req(req2), .f_o_imem_addr(addr2),
        .f_i_imem_ack(req2), .f_i_imem_data(data2),
        .f_o_instr(instr2), .f_o_pc(pc2), .f_o_ce(ce2)
    );

    // Capture what the DUT saw at each active edge
    always @(posedge d_clk) begin
        p_req   <= imem_req;
        p_ack   <= imem_ack;
        p_addr  <= imem_addr;
        p_stall <= stall;
        p_redir <= redirect;
        p_tgt   <= redirect_pc & ~32'h3;
        cnt     <= (!imem_req || imem_ack) ? 0 : cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge d_clk);
        @(negedge d_clk);
    endtask

    task automatic do_reset(input logic rnd);
        @(negedge d_clk);
        d_rst = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rnd_mode = rnd; rnd_ack = 1'b0;
        repeat (2) @(negedge d_clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_ce", {31'd0, ce}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        d_rst = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        ce;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t vt[14];

    initial begin
        int          n;
        int          ce_seen;
        logic        found;
        logic [31:0] exp_pc;
        int          delivered;

        // Zero-wait memory: back-to-back fetch, stall/hold, redirects
        vt[0]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0,  32'h0};
        vt[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  1'b1, 32'h0,  mw(32'h0)};
        vt[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  1'b1, 32'h4,  mw(32'h4)};
        vt[3]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h4,  mw(32'h4)};
        vt[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h4,  mw(32'h4)};
        vt[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h4,  mw(32'h4)};
        vt[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h4,  mw(32'h4)};
        vt[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hC,  1'b1, 32'h8,  mw(32'h8)};
        vt[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'hC,  mw(32'hC)};
        vt[9]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'hC,  mw(32'hC)};
        vt[10] = '{1'b1, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'hC,  mw(32'hC)};
        vt[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h84, 1'b1, 32'h80, mw(32'h80)};
        vt[12] = '{1'b0, 1'b1, 32'h43, 1'b1, 32'h40, 1'b0, 32'h80, mw(32'h80)};
        vt[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 32'h40, mw(32'h40)};

        lat = 1;
        do_reset(1'b0);
        for (int i = 0; i < 14; i++) begin
            stall = vt[i].stall; redirect = vt[i].redir; redirect_pc = vt[i].rpc;
            step();
            chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vt[i].req});
            if (vt[i].req) chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].addr);
            chk($sformatf("vec%0d_ce", i), {31'd0, ce}, {31'd0, vt[i].ce});
            chk($sformatf("vec%0d_pc", i), pc, vt[i].pc);
            chk($sformatf("vec%0d_instr", i), instr, vt[i].instr);
        end
        stall = 1'b0; redirect = 1'b0;

        // Reset PC near the top of the address space wraps to zero
        do_reset(1'b0);
        chk("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
        step();
        chk("wrap_req", {31'd0, req2}, 32'd1);
        chk("wrap_addr", addr2, 32'hFFFF_FFFC);
        step();
        chk("wrap_ce1", {31'd0, ce2}, 32'd1);
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        chk("wrap_instr1", instr2, mw(32'hFFFF_FFFC));
        step();
        chk("wrap_ce2", {31'd0, ce2}, 32'd1);
        chk("wrap_pc2", pc2, 32'h0);
        chk("wrap_instr2", instr2, mw(32'h0));
        chk("wrap_addr2", addr2, 32'h4);

        // Three-cycle memory: addr held 3 cycles, one pulse per ack
        lat = 3;
        do_reset(1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("lat3_addr%0d", k), imem_addr, 32'(4 * ((k - 1) / 3)));
            chk($sformatf("lat3_req%0d", k), {31'd0, imem_req}, 32'd1);
            if (k >= 4 && (k - 4) % 3 == 0) begin
                chk($sformatf("lat3_ce%0d", k), {31'd0, ce}, 32'd1);
                chk($sformatf("lat3_pc%0d", k), pc, 32'(4 * ((k - 4) / 3)));
            end else begin
                chk($sformatf("lat3_ce%0d", k), {31'd0, ce}, 32'd0);
            end
        end

        // Redirect while the fetch of 0x10 is outstanding
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (imem_req && imem_addr == 32'h10) found = 1'b1;
            else step();
        end
        chk("redir_find10", {31'd0, found}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        chk("redir_ce0", {31'd0, ce}, 32'd0);
        found = 1'b0; ce_seen = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (ce) ce_seen++;
            if (imem_req && imem_addr == 32'h40) found = 1'b1;
        end
        chk("redir_reach40", {31'd0, found}, 32'd1);
        chk("redir_no_stale", 32'(ce_seen), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (ce) found = 1'b1;
        end
        chk("redir_ce_seen", {31'd0, found}, 32'd1);
        chk("redir_pc", pc, 32'h40);
        chk("redir_instr", instr, mw(32'h40));

        // Asynchronous reset in the middle of an outstanding fetch
        d_rst = 1'b0;
        #1;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        chk("midrst_ce", {31'd0, ce}, 32'd0);
        chk("midrst_instr", instr, 32'd0);
        chk("midrst_pc", pc, 32'd0);

        // Randomized run against the program-order model
        do_reset(1'b1);
        exp_pc = 32'h0;
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = (i >= 2) && ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom & 32'h0000_FFFF;
            rnd_ack     = $urandom_range(0, 1) == 1;
            step();
            if (p_stall) chk("rnd_stall_ce", {31'd0, ce}, 32'd0);
            if (p_redir) begin
                chk("rnd_redir_ce", {31'd0, ce}, 32'd0);
                exp_pc = p_tgt;
            end else if (ce) begin
                chk("rnd_pc", pc, exp_pc);
                chk("rnd_instr", instr, mw(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (p_req && !p_ack) begin
                chk("rnd_req_held", {31'd0, imem_req}, 32'd1);
                chk("rnd_addr_stable", imem_addr, p_addr);
            end
            if (imem_req) chk("rnd_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        end
        stall = 1'b0; redirect = 1'b0;
        n = delivered;
        chk("rnd_progress", {31'd0, n > 100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
